// File: rtl/insn_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port plus downstream valid/stall.
// master = fetch controller, slave = memory/decode side.
interface insn_fetch_ctrl_if #(
  parameter int MEM_INSN_ADDR = 10,
  parameter int LEN_INSN      = 32
);
  logic [MEM_INSN_ADDR-1:0] mem_addr;
  logic [LEN_INSN-1:0]      mem_q;
  logic                     valid_o;
  logic [LEN_INSN-1:0]      insn;
  logic [MEM_INSN_ADDR-1:0] pc_o;
  logic                     stall_i;

  modport master (
    output mem_addr, valid_o, insn, pc_o,
    input  mem_q, stall_i
  );

  modport slave (
    input  mem_addr, valid_o, insn, pc_o,
    output mem_q, stall_i
  );
endinterface

// File: rtl/insn_fetch_ctrl.sv
// PC sequencer for a 1-cycle registered instruction memory.
// INSN_FETCH_CTRL_FETCH_CNT_EN adds the accepted-instruction counter.
module insn_fetch_ctrl #(
  parameter int MEM_INSN_ADDR = 10,
  parameter int LEN_INSN      = 32,
  parameter logic [MEM_INSN_ADDR-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MEM_INSN_ADDR-1:0] start_addr,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [MEM_INSN_ADDR-1:0] redirect_addr,
  insn_fetch_ctrl_if.master        bus,
  output logic                     busy,
  output logic [31:0]              fetch_cnt
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                   state_q, state_d;
  logic [MEM_INSN_ADDR-1:0] pc_q, pc_d;
  logic                     pend_q, pend_d;
  logic [MEM_INSN_ADDR-1:0] pend_addr_q, pend_addr_d;
  logic [MEM_INSN_ADDR-1:0] nxt;
  logic [LEN_INSN-1:0]      insn_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    nxt = redirect ? redirect_addr
        : (pend_q ? pend_addr_q : pc_q + 1'b1);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
        end
      end
      RUN: begin
        priority case (1'b1)
          halt: begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end
          bus.stall_i: begin
            if (redirect) begin
              pend_d      = 1'b1;
              pend_addr_d = redirect_addr;
            end
          end
          default: begin
            pc_d   = nxt;
            pend_d = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Address port carries exactly what pc_q loads, so mem_q tracks pc_q.
  always_comb begin
    bus.mem_addr = pc_d;
    bus.valid_o  = (state_q == RUN);
    busy         = (state_q == RUN);
  end

  assign insn_w   = bus.mem_q;
  assign bus.insn = insn_w;
  assign bus.pc_o = pc_q;

`ifdef INSN_FETCH_CTRL_FETCH_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (bus.valid_o && !bus.stall_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = cnt_q;
`else
  assign fetch_cnt = '0;
`endif

endmodule
